// File: rtl/park_occupancy.sv
// Parking-lot occupancy tracker: debounced entry/exit/leave sensors, an IDLE/ARMED entry FSM
// and a saturating car counter. Optional sticky count-error alarm built when PARK_OCC_ALARM_EN is defined.
module park_occupancy #(
    parameter int CAPACITY   = 8,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ent_sensor,
    input  logic       exit_sensor,
    input  logic       leave_sensor,
    output logic [7:0] occupancy,
    output logic       full,
    output logic       empty,
    output logic       ent_allow,
    output logic       car_in,
    output logic       entry_timeout,
    output logic       alarm
);

    localparam logic [7:0]  CAP_OCC  = 8'(CAPACITY);
    localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {IDLE, ARMED} state_t;

    // Sensor index: 0 = ent, 1 = exit, 2 = leave
    logic [2:0] raw_vec;
    logic [2:0] filt;
    logic [2:0] filt_d;
    logic [2:0] ev;
    logic [7:0] deb_cnt [3];

    state_t      state, next_state;
    logic [15:0] tmr, tmr_nxt;
    logic        car_in_nxt;
    logic        tmo_nxt;
    logic [7:0]  occ_nxt;
    logic        ent_ev, exit_ev, leave_ev;

    assign raw_vec  = {leave_sensor, exit_sensor, ent_sensor};
    assign ev       = filt & ~filt_d;
    assign ent_ev   = ev[0];
    assign exit_ev  = ev[1];
    assign leave_ev = ev[2];

    // Filtered level follows raw only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt   <= '0;
            filt_d <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            filt_d <= filt;
            for (int i = 0; i < 3; i++) begin
                if (raw_vec[i] != filt[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        filt[i]    <= raw_vec[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        tmr_nxt    = tmr;
        car_in_nxt = 1'b0;
        tmo_nxt    = 1'b0;
        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (ent_ev && !full) next_state = ARMED;
            end
            ARMED: begin
                if (exit_ev) begin
                    car_in_nxt = 1'b1;
                    next_state = IDLE;
                end else if (tmr == TMO_LAST) begin
                    tmo_nxt    = 1'b1;
                    next_state = IDLE;
                end else begin
                    tmr_nxt = tmr + 16'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A completed entry and a leave in the same cycle cancel out
    always_comb begin
        occ_nxt = occupancy;
        if (car_in_nxt && !leave_ev && occupancy < CAP_OCC)
            occ_nxt = occupancy + 8'd1;
        else if (leave_ev && !car_in_nxt && occupancy != 8'd0)
            occ_nxt = occupancy - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            tmr           <= '0;
            occupancy     <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            car_in        <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            state         <= next_state;
            tmr           <= tmr_nxt;
            occupancy     <= occ_nxt;
            full          <= (occ_nxt == CAP_OCC);
            empty         <= (occ_nxt == 8'd0);
            car_in        <= car_in_nxt;
            entry_timeout <= tmo_nxt;
        end
    end

    assign ent_allow = filt[0] & ~full;

`ifdef PARK_OCC_ALARM_EN
    logic alarm_set;
    assign alarm_set = (leave_ev && !car_in_nxt && occupancy == 8'd0) || (ent_ev && full);

    always_ff @(posedge clk) begin
        if (!reset_n) alarm <= 1'b0;
        else if (alarm_set) alarm <= 1'b1;
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_park_occupancy.sv
// Directed table-driven bench for park_occupancy (CAPACITY=4, DEB_CYCLES=4, TIMEOUT=64),
// plus hand-written sequences for reset mid-entry, sensor bounce and exact latency.
module tb_park_occupancy;

    localparam int CAP = 4;
`ifdef PARK_OCC_ALARM_EN
    localparam bit ALM_EN = 1'b1;
`else
    localparam bit ALM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ent_sensor, exit_sensor, leave_sensor;
    logic [7:0] occupancy;
    logic       full, empty, ent_allow, car_in, entry_timeout, alarm;

    park_occupancy #(.CAPACITY(CAP), .DEB_CYCLES(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .ent_sensor(ent_sensor), .exit_sensor(exit_sensor), .leave_sensor(leave_sensor),
        .occupancy(occupancy), .full(full), .empty(empty), .ent_allow(ent_allow),
        .car_in(car_in), .entry_timeout(entry_timeout), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ent, ext, lv;
        int cyc;
        int occ;
        bit full, empty, allow, alm;
        int cin, tmo;
    } step_t;

    step_t steps[$];
    int checks = 0;
    int errors = 0;
    int cin_cnt = 0;
    int tmo_cnt = 0;
    int c0, t0;

    always begin
        @(posedge clk);
        #1;
        if (car_in === 1'b1) cin_cnt++;
        if (entry_timeout === 1'b1) tmo_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit e, input bit x, input bit l, input int cyc, input int occ,
                       input bit f, input bit em, input bit al, input bit alm,
                       input int cin, input int tmo);
        step_t s;
        s = '{ent: e, ext: x, lv: l, cyc: cyc, occ: occ, full: f, empty: em,
              allow: al, alm: alm, cin: cin, tmo: tmo};
        steps.push_back(s);
    endtask

    // Arm, complete with an exit, then settle; o is the occupancy before the entry
    task automatic add_entry(input int o, input bit alm);
        add(1, 0, 0, 10, o,     o == CAP,       o == 0, 1, alm, 0, 0);
        add(0, 1, 0, 10, o + 1, (o + 1) == CAP, 0,      0, alm, 1, 0);
        add(0, 0, 0, 6,  o + 1, (o + 1) == CAP, 0,      0, alm, 0, 0);
    endtask

    task automatic set_in(input bit e, input bit x, input bit l);
        ent_sensor   = e;
        exit_sensor  = x;
        leave_sensor = l;
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0);
        tick();
        tick();
        check("rst_occ", occupancy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_allow", ent_allow, 0);
        check("rst_car_in", car_in, 0);
        check("rst_timeout", entry_timeout, 0);
        check("rst_alarm", alarm, 0);
        reset_n = 1'b1;
        tick();

        // Clean entry, exit in IDLE, leaves, leave at zero
        add(1, 0, 0, 10, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 10, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 6,  1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 6,  1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 10, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 6,  0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 10, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 6,  0, 0, 1, 0, 1, 0, 0);
        // Timeout then re-arm
        add(1, 0, 0, 10, 0, 0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 70, 0, 0, 1, 0, 1, 0, 1);
        add_entry(0, 1);
        add_entry(1, 1);
        add_entry(2, 1);
        add_entry(3, 1);
        // Full: ent ignored, later exit has nothing armed
        add(1, 0, 0, 10, 4, 1, 0, 0, 1, 0, 0);
        add(0, 1, 0, 10, 4, 1, 0, 0, 1, 0, 0);
        add(0, 0, 0, 6,  4, 1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 10, 3, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 6,  3, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 10, 2, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 6,  2, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 10, 1, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 6,  1, 0, 0, 0, 1, 0, 0);
        // Simultaneous exit and leave while ARMED at occupancy 1
        add(1, 0, 0, 10, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 1, 10, 1, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 6,  1, 0, 0, 0, 1, 0, 0);
        add_entry(1, 1);
        add_entry(2, 1);
        add(1, 0, 0, 10, 3, 0, 0, 1, 1, 0, 0);

        for (int i = 0; i < steps.size(); i++) begin
            set_in(steps[i].ent, steps[i].ext, steps[i].lv);
            c0 = cin_cnt;
            t0 = tmo_cnt;
            repeat (steps[i].cyc) tick();
            check($sformatf("s%0d_occ", i), occupancy, steps[i].occ);
            check($sformatf("s%0d_full", i), full, steps[i].full);
            check($sformatf("s%0d_empty", i), empty, steps[i].empty);
            check($sformatf("s%0d_allow", i), ent_allow, steps[i].allow);
            check($sformatf("s%0d_alarm", i), alarm, steps[i].alm & ALM_EN);
            check($sformatf("s%0d_car_in", i), cin_cnt - c0, steps[i].cin);
            check($sformatf("s%0d_timeout", i), tmo_cnt - t0, steps[i].tmo);
        end

        // Reset while ARMED at occupancy 3
        set_in(0, 0, 0);
        c0 = cin_cnt;
        t0 = tmo_cnt;
        reset_n = 1'b0;
        tick();
        check("midrst_occ", occupancy, 0);
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        check("midrst_allow", ent_allow, 0);
        check("midrst_alarm", alarm, 0);
        reset_n = 1'b1;
        repeat (70) tick();
        check("midrst_car_in", cin_cnt - c0, 0);
        check("midrst_timeout", tmo_cnt - t0, 0);
        set_in(0, 1, 0);
        repeat (10) tick();
        check("midrst_idle_exit_occ", occupancy, 0);
        check("midrst_idle_exit_cin", cin_cnt - c0, 0);
        set_in(0, 0, 0);
        repeat (6) tick();

        // Bounce on ent, then exact exit-to-occupancy latency
        c0 = cin_cnt;
        set_in(1, 0, 0); tick();
        set_in(0, 0, 0); tick();
        set_in(1, 0, 0); tick();
        set_in(0, 0, 0); tick();
        set_in(1, 0, 0);
        repeat (3) tick();
        check("bounce_allow_3", ent_allow, 0);
        tick();
        check("bounce_allow_4", ent_allow, 1);
        repeat (4) tick();
        set_in(1, 1, 0);
        repeat (4) tick();
        check("lat_occ_edge4", occupancy, 0);
        tick();
        check("lat_occ_edge5", occupancy, 1);
        check("lat_car_in_edge5", car_in, 1);
        check("lat_empty_edge5", empty, 0);
        repeat (8) tick();
        check("bounce_car_in_total", cin_cnt - c0, 1);
        check("bounce_occ_final", occupancy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/park_occupancy.md
PARK_OCCUPANCY -- requirements
Module: park_occupancy

Interface
REQ-001 Parameter CAPACITY, default 8: number of parking slots; legal range 1..255.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive stable cycles required to accept a sensor level change; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 64: cycles allowed in ARMED before the entry is abandoned; legal range 1..65535.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 ent_sensor  input  1  raw gate-approach sensor, active high.
REQ-007 exit_sensor  input  1  raw gate-passed sensor, active high.
REQ-008 leave_sensor  input  1  raw lot-exit sensor, active high.
REQ-009 occupancy  output  8  cars currently in the lot, registered.
REQ-010 full  output  1  high when occupancy == CAPACITY, registered.
REQ-011 empty  output  1  high when occupancy == 0, registered.
REQ-012 ent_allow  output  1  qualified ent_sensor for the downstream gate controller: the filtered ent_sensor level ANDed with !full.
REQ-013 car_in  output  1  one-cycle pulse when an entry completes.
REQ-014 entry_timeout  output  1  one-cycle pulse when an ARMED entry is abandoned.
REQ-015 alarm  output  1  sticky count-error flag (see Configuration).

Function
REQ-016 Each raw sensor SHALL pass through its own debouncer. The filtered value takes the raw value only after the raw value differs from the filtered value for DEB_CYCLES consecutive cycles. Any bounce restarts the run count.
REQ-017 An event SHALL be the 0->1 transition of a filtered signal. Occupancy and car_in become visible one cycle after the filtered rise, i.e. DEB_CYCLES+1 edges after a clean raw rise.
REQ-018 The entry FSM SHALL have two states, IDLE and ARMED.
  - IDLE -> ARMED on an ent event while !full.
  - An ent event while full is ignored.
REQ-019 In ARMED:
  - An exit event SHALL increment occupancy, pulse car_in, and return to IDLE.
  - If TIMEOUT cycles elapse with no exit event, the FSM SHALL pulse entry_timeout and return to IDLE with no count change.
REQ-020 The ARMED cycle counter SHALL clear on entry to ARMED and be 16 bits wide.
REQ-021 An exit event in IDLE SHALL be ignored.
REQ-022 A repeated ent event in ARMED SHALL be ignored; the timeout is not restarted.
REQ-023 A leave event SHALL decrement occupancy when occupancy > 0. A leave event at occupancy 0 leaves occupancy at 0.
REQ-024 An entry completion and a leave event in the same cycle SHALL leave occupancy unchanged. car_in still pulses.
REQ-025 Occupancy SHALL saturate at CAPACITY and never wrap in either direction.
REQ-026 full and empty SHALL be derived from the next occupancy value, so they update in the same cycle as occupancy.

Reset
REQ-027 While reset_n is low at a clock edge, the block SHALL reset as follows:
  - FSM to IDLE.
  - Debouncer filtered values and run counters to 0.
  - Timeout counter to 0.
  - Outputs: occupancy=0, empty=1, full=0, ent_allow=0, car_in=0, entry_timeout=0, alarm=0.
REQ-028 Reset asserted mid-ARMED SHALL abandon the entry with no car_in and no entry_timeout pulse.

Configuration
REQ-029 Macro PARK_OCC_ALARM_EN selects the alarm behaviour.
  - Defined: alarm SHALL set on an attempted decrement at occupancy 0, or on an ent event while full. It clears only by reset.
  - Undefined: alarm SHALL be tied 0, and no alarm logic is synthesised.

Verification
REQ-030 Clean entry: ent high 10 cycles, then exit high 10 cycles, DEB_CYCLES=4 -> car_in pulses once; occupancy 0->1 at edge 5 after the exit raw rise; empty 1->0.
REQ-031 Bounce: ent toggles 1,0,1,0 each cycle, then stays high -> FSM stays IDLE until 4 stable cycles elapse; exactly one ARMED entry.
REQ-032 Timeout: ent event with no exit for 64 cycles -> entry_timeout pulses once; occupancy unchanged; the next ent event re-arms.
REQ-033 Full lot, CAPACITY=2: two entries give full=1 and ent_allow=0; a third ent is ignored; with the macro defined, alarm=1.
REQ-034 Simultaneous: occupancy=1, exit and leave events in the same cycle while ARMED -> occupancy stays 1; car_in pulses.
REQ-035 Reset mid-ARMED at occupancy 3 -> next cycle occupancy=0, empty=1, FSM IDLE, no pulses.
